// File: rtl/sd_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_dma_pkg
// Description : Shared types and constants for the SD-to-DDR DMA job
//               scheduler. It holds the scheduler FSM state encoding, the
//               job descriptor struct and the default watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_dma_pkg;

  // Default watchdog limit, in sys_clk cycles, for one DMA job.
  localparam logic [31:0] SD_DMA_TIMEOUT_DEFAULT = 32'd50_000_000;

  // Job fields are carried at this width and narrowed to the instance's
  // SEC_WIDTH / ADDR_WIDTH where they reach the DMA control registers.
  localparam int JOB_FIELD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_CMPL   = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  typedef struct packed {
    logic [JOB_FIELD_W-1:0] start_sec;
    logic [JOB_FIELD_W-1:0] sec_num;
    logic [JOB_FIELD_W-1:0] ddr_base;
  } job_t;

endpackage
`default_nettype wire

// File: rtl/sd_dma_job_sched_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_onehot
// Description : Round-robin arbiter. The pointer names the first requester
//               searched; after a grant it moves to the one just past the
//               winner. The grant is combinational and the pointer moves
//               only when advance_i is high.
// Ports       : clk_i, rst_i      clock, async active-high reset
//               req_i [N]         request vector
//               advance_i         accept the current grant, move the pointer
//               grant_o [N]       one-hot grant (zero when no request)
//               grant_idx_o       index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_onehot #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Search N positions starting at the pointer. The first active request wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = 0;
    cand_idx    = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand     = (int'(ptr_q) + i) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = IDX_W'((int'(grant_idx_o) + 1) % N);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_dma_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : sd_dma_job_sched
// Description : Round-robin job scheduler in front of the SD-to-DDR read DMA.
//               It accepts one job from a requester and loads the DMA control
//               registers. It holds dma_start until dma_done arrives or the
//               watchdog expires, then pulses done/err back to the owner.
// Ports       : sys_clk, rst          clock, async active-high reset
//               req_valid/req_ready   per-requester handshake (ready = 1-cycle)
//               req_start_sec/sec_num/ddr_base  packed job buses, slice i = req i
//               req_done/req_err      completion pulse, err = watchdog timeout
//               dma_init_done/dma_done  status from the DMA engine
//               dma_start/start_sec/sec_num/ddr_base  DMA control outputs
//               busy, grant_id        status
// Revision    : 1.0 - initial release
// ============================================================================
module sd_dma_job_sched
  import sd_dma_pkg::*;
#(
  parameter  int          NUM_REQ        = 4,
  parameter  int          ADDR_WIDTH     = 32,
  parameter  int          SEC_WIDTH      = 32,
  parameter  logic [31:0] TIMEOUT_CYCLES = SD_DMA_TIMEOUT_DEFAULT,
  localparam int          IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*SEC_WIDTH-1:0]  req_start_sec,
  input  logic [NUM_REQ*SEC_WIDTH-1:0]  req_sec_num,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_ddr_base,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  input  logic                          dma_init_done,
  input  logic                          dma_done,
  output logic                          dma_start,
  output logic [SEC_WIDTH-1:0]          dma_start_sec,
  output logic [SEC_WIDTH-1:0]          dma_sec_num,
  output logic [ADDR_WIDTH-1:0]         dma_ddr_base,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_id
);

  state_e                  state_q,      state_d;
  logic [IDX_W-1:0]        grant_id_q,   grant_id_d;
  logic [SEC_WIDTH-1:0]    start_sec_q,  start_sec_d;
  logic [SEC_WIDTH-1:0]    sec_num_q,    sec_num_d;
  logic [ADDR_WIDTH-1:0]   ddr_base_q,   ddr_base_d;
  logic                    dma_start_q,  dma_start_d;
  logic                    err_q,        err_d;
  logic [31:0]             wdog_q,       wdog_d;

  logic [NUM_REQ-1:0]      w_grant;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_advance;
  logic                    w_timeout;
  logic                    w_job_pending;
  logic [NUM_REQ-1:0]      w_owner_oh;
  job_t                    w_sel_job;
  logic                    w_unused_job;

  rr_arbiter_onehot #(
    .N (NUM_REQ)
  ) u_arb (
    .clk_i       (sys_clk),
    .rst_i       (rst),
    .req_i       (req_valid),
    .advance_i   (w_advance),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx)
  );

  // The pointer moves only when a job is actually accepted.
  assign w_advance     = (state_q == ST_ARB) && (|w_grant);
  assign w_job_pending = dma_init_done && (|req_valid);
  assign w_timeout     = (TIMEOUT_CYCLES != 32'd0) &&
                         (wdog_q == (TIMEOUT_CYCLES - 32'd1));

  // Job descriptor of the granted requester, widened to the struct width.
  always_comb begin
    w_sel_job           = '0;
    w_sel_job.start_sec = JOB_FIELD_W'(req_start_sec[int'(w_grant_idx)*SEC_WIDTH +: SEC_WIDTH]);
    w_sel_job.sec_num   = JOB_FIELD_W'(req_sec_num[int'(w_grant_idx)*SEC_WIDTH +: SEC_WIDTH]);
    w_sel_job.ddr_base  = JOB_FIELD_W'(req_ddr_base[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // The widened upper bits are always zero. They are reduced here only so
  // that the lint tool does not flag them.
  assign w_unused_job = ^w_sel_job;

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    start_sec_d = start_sec_q;
    sec_num_d   = sec_num_q;
    ddr_base_d  = ddr_base_q;
    dma_start_d = dma_start_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (w_job_pending) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (|w_grant) begin
          grant_id_d  = w_grant_idx;
          start_sec_d = w_sel_job.start_sec[SEC_WIDTH-1:0];
          sec_num_d   = w_sel_job.sec_num[SEC_WIDTH-1:0];
          ddr_base_d  = w_sel_job.ddr_base[ADDR_WIDTH-1:0];
          err_d       = 1'b0;
          // A zero-length job completes without ever touching the DMA.
          state_d     = (w_sel_job.sec_num == '0) ? ST_CMPL : ST_LAUNCH;
        end else begin
          // The request was withdrawn before it was accepted.
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        // The DMA parameters have been stable for a full cycle. The rising
        // edge of start therefore sees valid values.
        dma_start_d = 1'b1;
        wdog_d      = 32'd0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (dma_done) begin
          // dma_done has priority over a timeout in the same cycle.
          dma_start_d = 1'b0;
          err_d       = 1'b0;
          state_d     = ST_CMPL;
        end else if (w_timeout) begin
          dma_start_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_CMPL;
        end else if (wdog_q != 32'hFFFF_FFFF) begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      ST_CMPL: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // With CMPL and GAP, dma_start stays low for at least two cycles.
        state_d = w_job_pending ? ST_ARB : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      start_sec_q <= '0;
      sec_num_q   <= '0;
      ddr_base_q  <= '0;
      dma_start_q <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      start_sec_q <= start_sec_d;
      sec_num_q   <= sec_num_d;
      ddr_base_q  <= ddr_base_d;
      dma_start_q <= dma_start_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign w_owner_oh    = NUM_REQ'(1) << grant_id_q;

  assign req_ready     = (state_q == ST_ARB)  ? w_grant    : '0;
  assign req_done      = (state_q == ST_CMPL) ? w_owner_oh : '0;
  assign req_err       = req_done & {NUM_REQ{err_q}};
  assign busy          = (state_q != ST_IDLE);
  assign grant_id      = grant_id_q;
  assign dma_start     = dma_start_q;
  assign dma_start_sec = start_sec_q;
  assign dma_sec_num   = sec_num_q;
  assign dma_ddr_base  = ddr_base_q;

endmodule
`default_nettype wire

// File: doc/sd_dma_job_sched.md
Name: sd_dma_job_sched

Overview:
- Multi-requester job scheduler in front of the SD-card-to-DDR read DMA engine.
- Accepts read jobs (start sector, sector count, DDR base address) from NUM_REQ requesters and arbitrates round-robin.
- Programs the DMA's start/sector/count/base controls, holds start until the DMA reports done (or a watchdog expires), then returns a per-requester done/error pulse.
- Sits between the CPU/accelerator job sources and the DMA control inputs; replaces direct single-master APB sequencing of the engine.

Parameters:
- NUM_REQ, 4, number of job requesters (2..8).
- ADDR_WIDTH, 32, DDR base address width.
- SEC_WIDTH, 32, sector address and sector count width.
- TIMEOUT_CYCLES, 32'd50_000_000, watchdog limit per job in sys_clk cycles; 0 disables the watchdog.

Ports:
- sys_clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester job request, held until accepted.
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- req_start_sec  in  NUM_REQ*SEC_WIDTH  packed start sector, slice i belongs to requester i.
- req_sec_num  in  NUM_REQ*SEC_WIDTH  packed sector count.
- req_ddr_base  in  NUM_REQ*ADDR_WIDTH  packed DDR destination base.
- req_done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- req_err  out  NUM_REQ  qualified by req_done; 1 = timeout.
- dma_init_done  in  1  SD card initialised.
- dma_done  in  1  DMA write-complete pulse.
- dma_start  out  1  DMA start level.
- dma_start_sec  out  SEC_WIDTH  DMA start sector.
- dma_sec_num  out  SEC_WIDTH  DMA sector count.
- dma_ddr_base  out  ADDR_WIDTH  DMA DDR base address.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent owner.

Behaviour:
- Reset values: all outputs 0, round-robin pointer 0, FSM in IDLE. Reset mid-job drops dma_start asynchronously; no req_done is issued.
- IDLE:
  - Waits for dma_init_done=1 and any req_valid.
  - Requests present while dma_init_done=0 remain pending; none are accepted or dropped.
- ARB (1 cycle):
  - Round-robin grant: search starts at (last_grant+1) mod NUM_REQ.
  - Pulse req_ready[g], capture slice g of the three job buses into dma_* registers, set grant_id=g.
  - The pointer advances only on grant.
- Zero-length job:
  - If the captured sec_num = 0, go straight to CMPL with err=0.
  - dma_start is never raised for it.
- LAUNCH (1 cycle):
  - Assert dma_start=1 one cycle after the dma_* registers are stable, so parameters are valid before the start rising edge.
  - Clear the watchdog counter.
- RUN:
  - Hold dma_start=1; increment the watchdog each cycle.
  - On dma_done: dma_start<=0, err=0, go to CMPL.
  - On watchdog reaching TIMEOUT_CYCLES-1 without dma_done: dma_start<=0, err=1, go to CMPL.
  - If dma_done and the timeout land in the same cycle, dma_done wins (err=0).
  - dma_done outside RUN is ignored.
- CMPL (1 cycle):
  - Pulse req_done[g] and req_err[g]=err.
  - dma_start is guaranteed low this cycle; the next job's start therefore always produces a fresh rising edge, which the DMA requires to reset its AXI write side.
- GAP (1 cycle):
  - Idle cycle so dma_start stays low for at least 2 cycles between jobs.
  - Then IDLE, or ARB directly if any req_valid is high and dma_init_done=1.
- dma_* outputs hold the last job's values after completion; they change only in ARB.
- A requester may re-assert req_valid in the cycle after its req_done. Fairness: with all requesters valid, grants rotate 0,1,2,3,0…
- Watchdog counter is 32-bit and saturating; unused when TIMEOUT_CYCLES=0.

Decomposition:
- Package sd_dma_pkg holds:
  - FSM state enum (IDLE, ARB, LAUNCH, RUN, CMPL, GAP);
  - job struct {start_sec, sec_num, ddr_base};
  - the default TIMEOUT_CYCLES constant.
- One sub-module, rr_arbiter_onehot (parameter N), provides the round-robin pointer and grant logic: inputs req/advance, outputs one-hot grant and grant index.

Test Plan:
- Single job: req0 (sec 0x100, num 8, base 0x8000_0000) → req_ready[0] pulse, dma_start rises 1 cycle after ARB with dma_* = those values; dma_done after 200 cycles → req_done[0]=1, req_err[0]=0, dma_start=0.
- Fairness: all 4 requesters valid and continuously re-requesting → grant order 0,1,2,3,0,1; dma_start low ≥2 cycles between consecutive jobs.
- Init gating: req1 valid while dma_init_done=0 for 100 cycles → no req_ready; dma_init_done→1 → req_ready[1] within 2 cycles.
- Timeout: TIMEOUT_CYCLES=1000, dma_done never asserted → req_done[g]=1, req_err[g]=1 exactly 1000 cycles after dma_start rises; dma_start drops.
- Zero-length job and collision: job with sec_num=0 → req_done with err=0 and dma_start never asserted. Separately, dma_done coincident with the final timeout cycle → err=0.
- Async reset in RUN → dma_start, busy, req_done all 0 immediately; after release the next request is granted from pointer 0.
